// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store traffic.
// One transaction in flight at a time; data wins by default, a wait counter bounds fetch starvation.
module mem_port_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        proto_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_e;
    typedef enum logic {OWN_IF, OWN_D} owner_e;

    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    state_e      state_q, state_d;
    owner_e      owner_q, owner_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic        proto_err_q, proto_err_d;
    logic        fetch_wins;

    assign fetch_wins = if_req & (~d_req | (wait_cnt_q == MaxWait));

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_gnt      = 1'b0;
        d_gnt       = 1'b0;
        if_rvalid   = 1'b0;
        d_rvalid    = 1'b0;
        // A response is only legal once the command has been accepted.
        proto_err_d = proto_err_q | (mem_rvalid & (state_q != ST_WAIT));

        unique case (state_q)
            ST_IDLE: begin
                if (if_req | d_req) begin
                    state_d = ST_ISSUE;
                    if (fetch_wins) begin
                        if_gnt      = 1'b1;
                        owner_d     = OWN_IF;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        mem_be_d    = 4'hF;
                    end else begin
                        d_gnt       = 1'b1;
                        owner_d     = OWN_D;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_be_d    = d_be;
                    end
                end
            end
            ST_ISSUE: begin
                if (mem_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    state_d   = ST_IDLE;
                    if_rvalid = (owner_q == OWN_IF);
                    d_rvalid  = (owner_q == OWN_D);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Counts every denied fetch cycle, including while another transaction is in flight.
        wait_cnt_d = wait_cnt_q;
        if (if_gnt) begin
            wait_cnt_d = '0;
        end else if (if_req && (wait_cnt_q < MaxWait)) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            wait_cnt_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign mem_req   = (state_q == ST_ISSUE);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign busy      = (state_q != ST_IDLE);
    assign proto_err = proto_err_q;

endmodule
